// File: rtl/fibo_result_checker_pkg.sv
// Shared types for the post-halt Fibonacci result checker.
// State encoding and sequence seeds used by the FSM and fibo_gen.
package fibo_result_checker_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int FIBO_SEED_PRV = 0;
    localparam int FIBO_SEED_CUR = 1;

endpackage

// File: rtl/fibo_result_checker_gen.sv
// Expected-value generator: holds the (prev, cur) Fibonacci pair.
// init loads the seed pair; step advances by one term, wrapping mod 2^DATA_W.
module fibo_gen
    import fibo_result_checker_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_init,
    input  logic              i_step,
    output logic [DATA_W-1:0] o_exp_cur
);

    logic [DATA_W-1:0] r_prv;
    logic [DATA_W-1:0] r_cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prv <= '0;
            r_cur <= '0;
        end else if (i_init) begin
            r_prv <= DATA_W'(FIBO_SEED_PRV);
            r_cur <= DATA_W'(FIBO_SEED_CUR);
        end else if (i_step) begin
            r_prv <= r_cur;
            r_cur <= r_cur + r_prv;
        end
    end

    assign o_exp_cur = r_cur;

endmodule

// File: rtl/fibo_result_checker.sv
// Post-halt checker: reads N_TERMS words from BASE_ADDR and compares them to f(1..N).
// Optional FIBO_DUMP_EN adds a dump port reporting every compared word.
module fibo_result_checker
    import fibo_result_checker_pkg::*;
#(
    parameter int              DATA_W    = 64,
    parameter int              ADDR_W    = 64,
    parameter int              N_TERMS   = 20,
    parameter longint unsigned BASE_ADDR = 1,
    parameter int              IDX_W     = $clog2(N_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [IDX_W-1:0]  fail_idx
`ifdef FIBO_DUMP_EN
    ,
    output logic              dump_valid,
    output logic [IDX_W-1:0]  dump_idx,
    output logic [DATA_W-1:0] dump_data
`endif
);

    state_t            r_state;
    logic              r_halt_q;
    logic [IDX_W-1:0]  r_idx;

    logic              w_start;
    logic              w_match;
    logic              w_last;
    logic              w_accept;
    logic              w_init;
    logic              w_step;
    logic [DATA_W-1:0] w_exp_cur;

    always_comb begin
        w_start  = halt & ~r_halt_q;
        w_match  = (rd_data == w_exp_cur);
        w_last   = (r_idx == IDX_W'(N_TERMS));
        w_accept = (r_state == S_WAIT) && rd_valid;
        w_init   = w_start && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_step   = w_accept && w_match && !w_last;
    end

    fibo_gen #(
        .DATA_W    (DATA_W)
    ) u_gen (
        .clk       (clk),
        .rst       (rst),
        .i_init    (w_init),
        .i_step    (w_step),
        .o_exp_cur (w_exp_cur)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_halt_q <= 1'b0;
            r_idx    <= '0;
            rd_req   <= 1'b0;
            rd_addr  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_idx <= '0;
        end else begin
            r_halt_q <= halt;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_state  <= S_REQ;
                        r_idx    <= IDX_W'(1);
                        rd_req   <= 1'b1;
                        rd_addr  <= ADDR_W'(BASE_ADDR);
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        fail_idx <= '0;
                    end
                end
                S_REQ: begin
                    rd_req  <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (rd_valid) begin
                        if (!w_match) begin
                            r_state  <= S_DONE;
                            fail_idx <= r_idx;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else if (w_last) begin
                            r_state <= S_DONE;
                            pass    <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            // next address is BASE + (idx+1) - 1
                            r_state <= S_REQ;
                            r_idx   <= r_idx + IDX_W'(1);
                            rd_req  <= 1'b1;
                            rd_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(r_idx);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef FIBO_DUMP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
        end else begin
            dump_valid <= w_accept;
            if (w_accept) begin
                dump_idx  <= r_idx;
                dump_data <= rd_data;
            end
        end
    end
`endif

endmodule

// File: doc/fibo_result_checker.md
Name: fibo_result_checker

Overview:
Hardware post-halt result checker; the read-side counterpart of the CPU program that writes the Fibonacci sequence into data memory.
On a rising edge of the CPU halt, it walks data memory words BASE_ADDR..BASE_ADDR+N_TERMS-1 over a request/valid read port.
It regenerates f(1)=f(2)=1, f(i)=f(i-1)+f(i-2) internally, compares each word and reports pass or the first failing index.
It sits beside top and Data_Mem and lets synthesized or FPGA builds self-check without a simulator.

Parameters:
DATA_W, 64, memory word / Fibonacci width
ADDR_W, 64, word-address width of the read port
N_TERMS, 20, number of sequence terms checked (>=2)
BASE_ADDR, 1, word address holding f(1)
IDX_W, $clog2(N_TERMS+1), width of index outputs

Ports:
clk  in  1  clock (rising edge)
rst  in  1  reset; asynchronous, active-high
halt  in  1  CPU halt level; start trigger is its rising edge
rd_req  out  1  one-cycle read request pulse
rd_addr  out  ADDR_W  word address, valid while rd_req=1
rd_valid  in  1  read-data strobe, ≥1 cycle after rd_req
rd_data  in  DATA_W  read word, valid while rd_valid=1
busy  out  1  check in progress
done  out  1  check finished (sticky)
pass  out  1  all N_TERMS matched; meaningful only when done=1
fail_idx  out  IDX_W  1-based index of first mismatch; 0 when pass

Behaviour:
- Reset (async): state=IDLE, halt_q=0; rd_req=0, rd_addr=0, busy=0, done=0, pass=0, fail_idx=0, idx=0, exp_prv=0, exp_cur=0.
- halt_q registers halt every cycle. start = halt & ~halt_q.
- FSM IDLE/REQ/WAIT/DONE, all outputs registered:
  - IDLE or DONE + start -> REQ. Set idx=1, exp_prv=0, exp_cur=1, busy=1, done=0, pass=0, fail_idx=0.
  - REQ: rd_req=1 for exactly 1 cycle, rd_addr=BASE_ADDR+idx-1 (mod 2^ADDR_W) -> WAIT.
  - WAIT: hold until rd_valid. Compare rd_data to exp_cur over the full DATA_W.
    - Mismatch -> DONE with fail_idx=idx, pass=0.
    - Match and idx==N_TERMS -> DONE with pass=1.
    - Otherwise idx+=1, exp_cur<=exp_cur+exp_prv, exp_prv<=exp_cur (mod 2^DATA_W, wrap silently) -> REQ.
  - DONE: busy=0, done=1. Results hold until rst or a new start.
- The exp seed pair (0,1) yields expected 1,1,2,3,5…
- Exactly one request outstanding. rd_valid outside WAIT is ignored. rd_valid in the same cycle as rd_req is ignored (minimum latency 1).
- start while busy (REQ/WAIT) is ignored.
- Per term: L+1 cycles for read latency L. done rises the cycle after the final compare.
- rst mid-check aborts immediately to reset values. No pending request is tracked after reset.
- No timeout: a missing rd_valid stalls in WAIT indefinitely.

Optional Feature:
FIBO_DUMP_EN — when defined, adds outputs dump_valid (1), dump_idx (IDX_W) and dump_data (DATA_W).
- On each accepted rd_valid in WAIT: dump_valid=1 for one cycle, dump_idx=idx, dump_data=rd_data. Compared words only; reset to 0.
- When not defined: ports absent, no extra logic, core behaviour identical.

Decomposition:
- Shared package: state encoding typedef (IDLE, REQ, WAIT, DONE), FIBO_SEED_PRV=0, FIBO_SEED_CUR=1.
- One natural sub-module, fibo_gen: holds the exp_prv/exp_cur pair with init and step controls and exposes exp_cur.
- The checker FSM instantiates fibo_gen.

Test Plan:
- Correct memory, latency 1: load words 1..20 with f(1..20), pulse halt -> 20 rd_req pulses at addresses 1..20; done=1, pass=1, fail_idx=0; done rises 40 cycles after the first REQ cycle.
- Corrupt word 7 = 12 (should be 13) -> stops after 7 reads, done=1, pass=0, fail_idx=7, no further rd_req.
- Variable latency 1–4 cycles plus spurious rd_valid pulses while in REQ -> spurious pulses ignored; still pass=1, exactly 20 requests.
- halt held high, then toggled again mid-check -> second edge ignored; after done, a fresh halt edge restarts (busy=1, done=0) and re-passes.
- Assert rst during the 5th WAIT -> all outputs 0 immediately (asynchronous); a later halt edge yields a full correct check.
- FIBO_DUMP_EN defined, correct memory -> 20 dump_valid pulses, dump_idx 1..20, dump_data 1,1,2,…,6765.
